// File: rtl/count_bcd_decoder.sv
// Binary-to-BCD converter for the stopwatch packed count (hi*100 + lo), driving four FND digits.
// Optional leading-zero blanking is enabled by defining COUNT_BCD_BLANK_EN.
module count_bcd_decoder #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_valid,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_ovf,
  output logic [3:0]       o_digit_1,
  output logic [3:0]       o_digit_10,
  output logic [3:0]       o_digit_100,
  output logic [3:0]       o_digit_1000
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int                CntW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]  MaxVal   = WIDTH'(MAX_VAL);
  localparam logic [CntW-1:0]   LastIter = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             resOvf_q, resOvf_d;
  logic [15:0]      dig_q, dig_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [15:0]      bcdAdj;
  logic [15:0]      digFmt;
  logic             overRange;

  function automatic logic [15:0] addThree(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (b[4*n +: 4] >= 4'd5) begin
        r[4*n +: 4] = b[4*n +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

`ifdef COUNT_BCD_BLANK_EN
  // Blank leading zeros from thousands down to tens; units always shown.
  function automatic logic [15:0] fmtDigits(input logic [15:0] b);
    logic [15:0] r;
    logic        lead;
    r    = b;
    lead = 1'b1;
    for (int n = 3; n >= 1; n--) begin
      if (lead && (b[4*n +: 4] == 4'd0)) begin
        r[4*n +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [15:0] fmtDigits(input logic [15:0] b);
    return b;
  endfunction
`endif

  assign overRange = (i_count > MaxVal);

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    resOvf_d = resOvf_q;
    dig_d    = dig_q;
    valid_d  = 1'b0;
    // Busy is registered one cycle late so it stays high through the o_valid cycle.
    busy_d   = (state_q != IDLE);
    bcdAdj   = addThree(bcd_q);
    digFmt   = fmtDigits(bcd_q);

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          bin_d   = overRange ? MaxVal : i_count;
          ovf_d   = overRange;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dig_d    = digFmt;
        resOvf_d = ovf_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      resOvf_q <= 1'b0;
      dig_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      resOvf_q <= resOvf_d;
      dig_q    <= dig_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_valid      = valid_q;
  assign o_ovf        = resOvf_q;
  assign o_digit_1    = dig_q[3:0];
  assign o_digit_10   = dig_q[7:4];
  assign o_digit_100  = dig_q[11:8];
  assign o_digit_1000 = dig_q[15:12];

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Testbench for count_bcd_decoder: directed scenarios plus randomized requests and resets
// against a cycle-level timeline model of the converter.
module tb_count_bcd_decoder;

  logic        clk;
  logic        reset;
  logic [13:0] i_count;
  logic        i_valid;
  logic        o_busy;
  logic        o_valid;
  logic        o_ovf;
  logic [3:0]  o_digit_1;
  logic [3:0]  o_digit_10;
  logic [3:0]  o_digit_100;
  logic [3:0]  o_digit_1000;
  logic [15:0] dutDigits;

  int nChecks = 0;
  int nFails  = 0;

`ifdef COUNT_BCD_BLANK_EN
  localparam logic [15:0] Lit0   = 16'hFFF0;
  localparam logic [15:0] Lit42  = 16'hFF42;
  localparam logic [15:0] Lit100 = 16'hF100;
`else
  localparam logic [15:0] Lit0   = 16'h0000;
  localparam logic [15:0] Lit42  = 16'h0042;
  localparam logic [15:0] Lit100 = 16'h0100;
`endif

  count_bcd_decoder #(.WIDTH(14), .MAX_VAL(9999)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_count      (i_count),
    .i_valid      (i_valid),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_ovf        (o_ovf),
    .o_digit_1    (o_digit_1),
    .o_digit_10   (o_digit_10),
    .o_digit_100  (o_digit_100),
    .o_digit_1000 (o_digit_1000)
  );

  assign dutDigits = {o_digit_1000, o_digit_100, o_digit_10, o_digit_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] expectDigits(input int c);
    int v;
    int d[4];
    v    = (c > 9999) ? 9999 : c;
    d[3] = v / 1000;
    d[2] = (v / 100) % 10;
    d[1] = (v / 10) % 10;
    d[0] = v % 10;
`ifdef COUNT_BCD_BLANK_EN
    if (d[3] == 0) begin
      d[3] = 15;
      if (d[2] == 0) begin
        d[2] = 15;
        if (d[1] == 0) d[1] = 15;
      end
    end
`endif
    return {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
  endfunction

  // Timeline model: a request accepted at edge T resolves after edge T+15 and frees the block at T+16.
  int          cyc      = 0;
  bit          mPend    = 1'b0;
  int          mAccept  = 0;
  logic [15:0] mPendDig = '0;
  logic        mPendOvf = 1'b0;
  logic [15:0] mDig     = '0;
  logic        mOvf     = 1'b0;
  logic        mValid   = 1'b0;
  logic        mBusy    = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mPend  = 1'b0;
      mDig   = '0;
      mOvf   = 1'b0;
      mValid = 1'b0;
      mBusy  = 1'b0;
    end else begin
      if ((!mPend || cyc >= mAccept + 16) && i_valid) begin
        mPend    = 1'b1;
        mAccept  = cyc;
        mPendDig = expectDigits(int'(i_count));
        mPendOvf = (int'(i_count) > 9999);
      end
      mValid = mPend && (cyc == mAccept + 15);
      if (mValid) begin
        mDig = mPendDig;
        mOvf = mPendOvf;
      end
      mBusy = mPend && (cyc >= mAccept + 1) && (cyc <= mAccept + 15);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("reset_busy", o_busy, 0);
      checkOutput("reset_valid", o_valid, 0);
      checkOutput("reset_ovf", o_ovf, 0);
      checkOutput("reset_digits", dutDigits, 0);
    end else begin
      checkOutput("model_busy", o_busy, mBusy);
      checkOutput("model_valid", o_valid, mValid);
      checkOutput("model_ovf", o_ovf, mOvf);
      checkOutput("model_digits", dutDigits, mDig);
    end
  end

  task automatic applyStimulus(input logic [13:0] value);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_count = value;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [15:0] expDig, input logic expOvf);
    int k;
    int busyCnt;
    k       = 0;
    busyCnt = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (o_busy) busyCnt++;
      if (o_valid) break;
    end
    checkOutput({tag, "_latency"}, k, 15);
    checkOutput({tag, "_busycycles"}, busyCnt, 15);
    checkOutput({tag, "_digits"}, dutDigits, expDig);
    checkOutput({tag, "_ovf"}, o_ovf, expOvf);
  endtask

  initial begin
    int pulses;
    int firstPulse;
    int lastPulse;
    reset   = 1'b0;
    i_valid = 1'b0;
    i_count = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init_busy", o_busy, 0);
    checkOutput("init_digits", dutDigits, 16'h0000);
    reset = 1'b1;

    applyStimulus(14'd5999);
    waitResult("req5999", 16'h5999, 1'b0);

    applyStimulus(14'd0);
    waitResult("req0", Lit0, 1'b0);
    applyStimulus(14'd1159);
    waitResult("req1159", 16'h1159, 1'b0);

    applyStimulus(14'd16383);
    waitResult("req16383", 16'h9999, 1'b1);
    applyStimulus(14'd10000);
    waitResult("req10000", 16'h9999, 1'b1);
    applyStimulus(14'd9999);
    waitResult("req9999", 16'h9999, 1'b0);

    $display("[TB] ignored requests while busy");
    applyStimulus(14'd42);
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (o_valid) pulses++;
      i_valid = ((k + 1) == 3) || ((k + 1) == 10);
      i_count = 14'd7777;
    end
    i_valid = 1'b0;
    checkOutput("ignore_pulses", pulses, 1);
    checkOutput("ignore_digits", dutDigits, Lit42);
    applyStimulus(14'd7777);
    waitResult("req7777", 16'h7777, 1'b0);

    $display("[TB] reset mid-conversion");
    applyStimulus(14'd5999);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_valid) pulses++;
    end
    checkOutput("abort_pulses", pulses, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_digits", dutDigits, 16'h0000);
    applyStimulus(14'd1234);
    waitResult("req1234", 16'h1234, 1'b0);

    $display("[TB] back-to-back requests");
    @(posedge clk); #1;
    i_valid    = 1'b1;
    i_count    = 14'd100;
    pulses     = 0;
    firstPulse = -1;
    lastPulse  = -1;
    for (int k = 1; k <= 82; k++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        pulses++;
        if (firstPulse < 0) begin
          firstPulse = k;
          checkOutput("b2b_first_digits", dutDigits, Lit100);
        end else begin
          checkOutput("b2b_spacing", k - lastPulse, 16);
        end
        lastPulse = k;
      end
      i_count = 14'(100 + k);
    end
    i_valid = 1'b0;
    checkOutput("b2b_first_pulse", firstPulse, 16);
    checkOutput("b2b_pulses", pulses, 5);
    repeat (20) @(posedge clk);

    $display("[TB] randomized requests");
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      i_valid = ($urandom_range(0, 3) == 0);
      i_count = ($urandom_range(0, 2) == 0) ? 14'($urandom_range(10000, 16383))
                                            : 14'($urandom_range(0, 9999));
      reset   = ($urandom_range(0, 299) != 0);
    end
    #1;
    reset   = 1'b1;
    i_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
